// File: rtl/xyz_frame_pkg.sv
// rtl/xyz_frame_pkg.sv - shared states and frame-length constants for the x/y/z deserializer
package xyz_frame_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_e;

   localparam int DATA_BEATS   = 3;
   localparam int PARITY_BEATS = 1;
   // Beat index spans the data beats plus the optional parity beat.
   localparam int IDX_W        = $clog2(DATA_BEATS + PARITY_BEATS);
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc_i,
   input  logic         clear_i,
   output logic [W-1:0] count_o
);
   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/xyz_frame_deserializer.sv
// rtl/xyz_frame_deserializer.sv - serial bit stream to x/y/z frame assembler with parity, timeout and resync
module xyz_frame_deserializer
   import xyz_frame_pkg::*;
#(
   parameter bit PARITY_EN = 1'b1,
   parameter int TIMEOUT   = 15,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 sin_valid,
   output logic                 sin_ready,
   input  logic                 sin_data,
   input  logic                 sin_sof,
   output logic                 x,
   output logic                 y,
   output logic                 z,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 busy
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] idle_q, idle_d;
   logic             sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
   logic             x_q, x_d, y_q, y_d, z_q, z_d;
   logic             frame_err_q;
   logic             drop;
   logic             beat;

   assign sin_ready = (state_q != HOLD);
   assign beat      = sin_valid && sin_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      idle_d  = idle_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      sz_d    = sz_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      drop    = 1'b0;
      unique case (state_q)
         IDLE: begin
            idle_d = '0;
            if (beat && sin_sof) begin
               sx_d    = sin_data;
               idx_d   = IDX_W'(1);
               state_d = SHIFT;
            end
         end
         SHIFT, PARITY: begin
            if (beat) begin
               idle_d = '0;
               if (sin_sof) begin
                  drop    = 1'b1;
                  sx_d    = sin_data;
                  idx_d   = IDX_W'(1);
                  state_d = SHIFT;
               end else if (state_q == PARITY) begin
                  if (sx_q ^ sy_q ^ sz_q ^ sin_data) begin
                     drop    = 1'b1;
                     state_d = IDLE;
                  end else begin
                     x_d     = sx_q;
                     y_d     = sy_q;
                     z_d     = sz_q;
                     state_d = HOLD;
                  end
               end else if (idx_q == IDX_W'(DATA_BEATS - 1)) begin
                  sz_d = sin_data;
                  if (PARITY_EN) begin
                     state_d = PARITY;
                  end else begin
                     x_d     = sx_q;
                     y_d     = sy_q;
                     z_d     = sin_data;
                     state_d = HOLD;
                  end
               end else begin
                  sy_d  = sin_data;
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (idle_q == CNT_LAST) begin
               // An accepted beat on the expiry cycle takes the branch above instead.
               drop    = 1'b1;
               idle_d  = '0;
               state_d = IDLE;
            end else begin
               idle_d = idle_q + CNT_W'(1);
            end
         end
         HOLD: begin
            idle_d = '0;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         idle_q      <= '0;
         sx_q        <= 1'b0;
         sy_q        <= 1'b0;
         sz_q        <= 1'b0;
         x_q         <= 1'b0;
         y_q         <= 1'b0;
         z_q         <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         idle_q      <= idle_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         sz_q        <= sz_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         frame_err_q <= drop;
      end
   end

   sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
      .clk     (clk),
      .rstn    (rstn),
      .inc_i   (drop),
      .clear_i (1'b0),
      .count_o (err_cnt)
   );

   assign x         = x_q;
   assign y         = y_q;
   assign z         = z_q;
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);
   assign frame_err = frame_err_q;
endmodule

// File: tb/tb_xyz_frame_deserializer.sv
// tb/tb_xyz_frame_deserializer.sv - self-checking bench for xyz_frame_deserializer against a frame-level model
module tb_xyz_frame_deserializer;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic sin_valid = 1'b0, sin_data = 1'b0, sin_sof = 1'b0, out_ready = 1'b1;

   logic       sin_ready_a, x_a, y_a, z_a, out_valid_a, frame_err_a, busy_a;
   logic [7:0] err_cnt_a;
   logic       sin_ready_b, x_b, y_b, z_b, out_valid_b, frame_err_b, busy_b;
   logic [1:0] err_cnt_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   xyz_frame_deserializer #(.PARITY_EN(1'b1), .TIMEOUT(15), .ERR_CNT_W(8)) dut_a (
      .clk(clk), .rstn(rstn), .sin_valid(sin_valid), .sin_ready(sin_ready_a),
      .sin_data(sin_data), .sin_sof(sin_sof), .x(x_a), .y(y_a), .z(z_a),
      .out_valid(out_valid_a), .out_ready(out_ready), .frame_err(frame_err_a),
      .err_cnt(err_cnt_a), .busy(busy_a)
   );

   xyz_frame_deserializer #(.PARITY_EN(1'b0), .TIMEOUT(4), .ERR_CNT_W(2)) dut_b (
      .clk(clk), .rstn(rstn), .sin_valid(sin_valid), .sin_ready(sin_ready_b),
      .sin_data(sin_data), .sin_sof(sin_sof), .x(x_b), .y(y_b), .z(z_b),
      .out_valid(out_valid_b), .out_ready(out_ready), .frame_err(frame_err_b),
      .err_cnt(err_cnt_b), .busy(busy_b)
   );

   // Frame-level model: bits collected so far, a presented frame, and the drop count.
   typedef struct {
      bit       hold;
      int       nb;
      bit [3:0] b;
      int       idle;
      bit       ex, ey, ez;
      bit       ferr;
      int       cnt;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mreset();
      mdl_t r;
      r.hold = 0; r.nb = 0; r.b = '0; r.idle = 0;
      r.ex = 0; r.ey = 0; r.ez = 0; r.ferr = 0; r.cnt = 0;
      return r;
   endfunction

   function automatic mdl_t step(mdl_t m, bit p, int to, int maxc, bit v, bit sof, bit d, bit ordy);
      mdl_t n = m;
      bit drop = 0;
      int flen = p ? 4 : 3;
      n.ferr = 0;
      if (m.hold) begin
         if (ordy) n.hold = 0;
      end else if (v) begin
         if (sof) begin
            if (m.nb > 0) drop = 1;
            n.b = '0; n.b[0] = d; n.nb = 1; n.idle = 0;
         end else if (m.nb > 0) begin
            n.b[m.nb] = d; n.nb = m.nb + 1; n.idle = 0;
            if (n.nb == flen) begin
               n.nb = 0;
               if (p && (^n.b)) drop = 1;
               else begin
                  n.hold = 1; n.ex = n.b[0]; n.ey = n.b[1]; n.ez = n.b[2];
               end
            end
         end
      end else if (m.nb > 0) begin
         n.idle = m.idle + 1;
         if (n.idle == to) begin
            drop = 1; n.nb = 0; n.idle = 0;
         end
      end
      if (drop) begin
         n.ferr = 1;
         if (n.cnt < maxc) n.cnt = n.cnt + 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ma <= mreset();
         mb <= mreset();
      end else begin
         ma <= step(ma, 1'b1, 15, 255, sin_valid, sin_sof, sin_data, out_ready);
         mb <= step(mb, 1'b0, 4, 3, sin_valid, sin_sof, sin_data, out_ready);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("A.sin_ready", int'(sin_ready_a), int'(!ma.hold));
      chk("A.out_valid", int'(out_valid_a), int'(ma.hold));
      chk("A.x", int'(x_a), int'(ma.ex));
      chk("A.y", int'(y_a), int'(ma.ey));
      chk("A.z", int'(z_a), int'(ma.ez));
      chk("A.frame_err", int'(frame_err_a), int'(ma.ferr));
      chk("A.err_cnt", int'(err_cnt_a), ma.cnt);
      chk("A.busy", int'(busy_a), int'(ma.hold || ma.nb > 0));
      chk("B.sin_ready", int'(sin_ready_b), int'(!mb.hold));
      chk("B.out_valid", int'(out_valid_b), int'(mb.hold));
      chk("B.x", int'(x_b), int'(mb.ex));
      chk("B.y", int'(y_b), int'(mb.ey));
      chk("B.z", int'(z_b), int'(mb.ez));
      chk("B.frame_err", int'(frame_err_b), int'(mb.ferr));
      chk("B.err_cnt", int'(err_cnt_b), mb.cnt);
      chk("B.busy", int'(busy_b), int'(mb.hold || mb.nb > 0));
   end

   task automatic beat(input bit s, input bit d);
      sin_valid = 1'b1; sin_sof = s; sin_data = d;
      @(posedge clk); #1;
      sin_valid = 1'b0; sin_sof = 1'b0; sin_data = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int quiet = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.sin_ready", int'(sin_ready_a), 1);
      chk("rst.out_valid", int'(out_valid_a), 0);
      chk("rst.err_cnt", int'(err_cnt_a), 0);
      chk("rst.busy", int'(busy_a), 0);
      rstn = 1'b1;
      idle(1);

      // Good parity frame x=1 y=0 z=1.
      beat(1, 1); beat(0, 0); beat(0, 1); beat(0, 0);
      chk("t1.out_valid", int'(out_valid_a), 1);
      chk("t1.xyz", int'({x_a, y_a, z_a}), 5);
      chk("t1.sin_ready", int'(sin_ready_a), 0);
      chk("t1.frame_err", int'(frame_err_a), 0);
      idle(1);
      chk("t1.out_valid_after", int'(out_valid_a), 0);
      chk("t1.sin_ready_after", int'(sin_ready_a), 1);

      // Parity error.
      beat(1, 1); beat(0, 0); beat(0, 1); beat(0, 1);
      chk("t2.frame_err", int'(frame_err_a), 1);
      chk("t2.err_cnt", int'(err_cnt_a), 1);
      chk("t2.out_valid", int'(out_valid_a), 0);
      chk("t2.busy", int'(busy_a), 0);
      idle(1);
      chk("t2.frame_err_pulse", int'(frame_err_a), 0);

      // Back-pressure in HOLD.
      out_ready = 1'b0;
      beat(1, 0); beat(0, 1); beat(0, 1); beat(0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("t3.out_valid", int'(out_valid_a), 1);
         chk("t3.xyz", int'({x_a, y_a, z_a}), 3);
         chk("t3.sin_ready", int'(sin_ready_a), 0);
         idle(1);
      end
      out_ready = 1'b1;
      idle(1);
      chk("t3.release", int'(out_valid_a), 0);

      // Timeout after 15 idle cycles, then a beat landing on the expiry cycle.
      beat(1, 1);
      idle(14);
      chk("t4.no_err_yet", int'(frame_err_a), 0);
      chk("t4.busy", int'(busy_a), 1);
      idle(1);
      chk("t4.frame_err", int'(frame_err_a), 1);
      chk("t4.err_cnt", int'(err_cnt_a), 2);
      chk("t4.idle", int'(busy_a), 0);
      beat(1, 1);
      idle(14);
      beat(0, 1); beat(0, 0); beat(0, 0);
      chk("t4.beat_wins", int'(out_valid_a), 1);
      chk("t4.xyz", int'({x_a, y_a, z_a}), 6);
      chk("t4.err_cnt_same", int'(err_cnt_a), 2);
      idle(1);

      // Resync on a mid-frame sof, then a stray beat in IDLE.
      beat(1, 0); beat(0, 1); beat(1, 1);
      chk("t5.frame_err", int'(frame_err_a), 1);
      chk("t5.err_cnt", int'(err_cnt_a), 3);
      beat(0, 0); beat(0, 1); beat(0, 0);
      chk("t5.out_valid", int'(out_valid_a), 1);
      chk("t5.xyz", int'({x_a, y_a, z_a}), 5);
      idle(1);
      beat(0, 1);
      chk("t5.stray_busy", int'(busy_a), 0);
      chk("t5.stray_err_cnt", int'(err_cnt_a), 3);
      idle(2);

      // Five timeouts: the 2-bit counter saturates.
      repeat (5) begin
         beat(1, 1);
         idle(20);
      end
      chk("t6.sat_b", int'(err_cnt_b), 3);
      chk("t6.cnt_a", int'(err_cnt_a), 8);

      for (int i = 0; i < 3000; i++) begin
         if (quiet > 0) begin
            quiet--;
            sin_valid = 1'b0;
         end else begin
            if ($urandom_range(40) == 0) quiet = int'($urandom_range(20, 5));
            sin_valid = ($urandom_range(9) < 7);
         end
         sin_sof   = ($urandom_range(5) == 0);
         sin_data  = 1'($urandom_range(1));
         out_ready = ($urandom_range(2) != 0);
         @(posedge clk); #1;
      end

      // Asynchronous reset mid-SHIFT.
      sin_valid = 1'b0; sin_sof = 1'b0; sin_data = 1'b0; out_ready = 1'b1;
      idle(20);
      beat(1, 1); beat(0, 0);
      chk("t6.shift_busy", int'(busy_a), 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("t6.rst_busy", int'(busy_a), 0);
      chk("t6.rst_err_cnt_a", int'(err_cnt_a), 0);
      chk("t6.rst_err_cnt_b", int'(err_cnt_b), 0);
      chk("t6.rst_sin_ready", int'(sin_ready_a), 1);
      chk("t6.rst_xyz", int'({x_a, y_a, z_a, out_valid_a, frame_err_a}), 0);
      #10;
      rstn = 1'b1;
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
